// File: rtl/serie_paralelo_8b_pkg.sv
// Shared constants and state encoding for the serial receive path and the 8->32 packer.
package serie_paralelo_8b_pkg;

  localparam logic [7:0] COMMA            = 8'hBC;
  localparam int unsigned BC_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    ALIGNED   = 2'd1,
    ACTIVE    = 2'd2
  } sp_state_t;

endpackage

// File: rtl/serie_paralelo_8b.sv
// Serial-to-parallel receiver: MSB-first, comma byte-alignment, link-up after BC_COUNT aligned commas.
// Byte appears on the edge sampling its last bit and is held 8 clk_32f cycles; no backpressure.
module serie_paralelo_8b
  import serie_paralelo_8b_pkg::*;
#(
  parameter int unsigned BC_COUNT = BC_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] BC_TGT = BC_COUNT[3:0];

  sp_state_t  state, state_d;
  // Only 7 bits are stored: the 8th bit of every window is the live data_in.
  logic [6:0] sr;
  logic [7:0] next_sr;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [3:0] bc_cnt, bc_cnt_d;
  logic [7:0] data_d;
  logic       valid_d;
  logic       byte_done;

  assign next_sr   = {sr, data_in};
  assign byte_done = (bit_cnt == 3'd7);
  assign active    = (state == ACTIVE);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= UNALIGNED;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= next_sr[6:0];
      bit_cnt   <= bit_cnt_d;
      bc_cnt    <= bc_cnt_d;
      data_out  <= data_d;
      valid_out <= valid_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bc_cnt_d  = bc_cnt;
    data_d    = data_out;
    valid_d   = valid_out;
    unique case (state)
      UNALIGNED: begin
        if (next_sr == COMMA) begin
          bit_cnt_d = '0;
          bc_cnt_d  = 4'd1;
          state_d   = (BC_COUNT == 1) ? ACTIVE : ALIGNED;
        end
      end
      ALIGNED: begin
        bit_cnt_d = byte_done ? 3'd0 : bit_cnt + 3'd1;
        if (byte_done) begin
          if (next_sr == COMMA) begin
            bc_cnt_d = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == BC_TGT) state_d = ACTIVE;
          end else begin
            bc_cnt_d = '0;
            state_d  = UNALIGNED;
          end
        end
      end
      ACTIVE: begin
        // No loss-of-sync detection: only reset leaves this state.
        bit_cnt_d = byte_done ? 3'd0 : bit_cnt + 3'd1;
        if (byte_done) begin
          data_d  = next_sr;
          valid_d = (next_sr != COMMA);
        end
      end
      default: state_d = UNALIGNED;
    endcase
  end

endmodule

// File: tb/tb_serie_paralelo_8b.sv
// Self-checking bench for serie_paralelo_8b: directed timing checks plus a byte-level reference model.
module tb_serie_paralelo_8b;

  localparam logic [7:0] BC  = 8'hBC;
  localparam int         BCN = 4;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;
  int bitno    = 0;

  // Reference model: bits since alignment, commas seen, last delivered byte.
  int         m_win;
  bit         m_hunt;
  int         m_bits;
  int         m_commas;
  bit         m_active;
  logic [7:0] m_data;
  bit         m_valid;

  serie_paralelo_8b dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic void model_reset();
    m_win = 0; m_hunt = 1; m_bits = 0; m_commas = 0;
    m_active = 0; m_data = 8'h00; m_valid = 0;
  endfunction

  function automatic void model_bit(input logic b);
    m_win = ((m_win << 1) | int'(b)) & 255;
    if (!m_active && m_hunt) begin
      if (m_win == int'(BC)) begin
        m_hunt = 0; m_bits = 0; m_commas = 1;
        if (m_commas == BCN) m_active = 1;
      end
    end else begin
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (!m_active) begin
          if (m_win == int'(BC)) begin
            m_commas++;
            if (m_commas == BCN) m_active = 1;
          end else begin
            m_hunt = 1; m_commas = 0;
          end
        end else begin
          m_data  = 8'(m_win);
          m_valid = (m_win != int'(BC));
        end
      end
    end
  endfunction

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    model_bit(b);
    bitno++;
  endtask

  task automatic pulse_reset();
    reset_L = 1'b0;
    model_reset();
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    bitno = 0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      data_in = i[0];
      @(posedge clk_32f);
      #1;
      n_checks++;
      if ({active, valid_out, data_out} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: act=%b vld=%b dat=%h, want 0/0/00", i, active, valid_out, data_out);
      end
    end
    reset_L = 1'b1;
    bitno = 0;
  endtask

  task automatic test_align();
    logic [7:0] pre;
    logic [7:0] b;
    pre = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) begin
      send_bit(pre[i]);
      n_checks++;
      if ({active, valid_out, data_out} !== 10'b0) begin
        n_fail++;
        $display("FAIL align_pre bit%0d: act=%b vld=%b dat=%h, want 0/0/00", bitno, active, valid_out, data_out);
      end
    end
    for (int j = 0; j < 4; j++) begin
      b = BC;
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        n_checks++;
        if (active !== (bitno >= 35) || valid_out !== 1'b0 || data_out !== 8'h00) begin
          n_fail++;
          $display("FAIL align bit%0d: act=%b vld=%b dat=%h, want act=%b vld=0 dat=00",
                   bitno, active, valid_out, data_out, bitno >= 35);
        end
      end
    end
  endtask

  task automatic test_payload();
    logic [7:0] pay [4];
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_v;
    pay = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    for (int j = 0; j < 4; j++) begin
      b = pay[j];
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        exp_d = (bitno >= 43) ? pay[(bitno - 43) / 8] : 8'h00;
        exp_v = (bitno >= 43);
        n_checks++;
        if (active !== 1'b1 || valid_out !== exp_v || data_out !== exp_d) begin
          n_fail++;
          $display("FAIL payload bit%0d: act=%b vld=%b dat=%h, want act=1 vld=%b dat=%h",
                   bitno, active, valid_out, data_out, exp_v, exp_d);
        end
      end
    end
  endtask

  task automatic test_comma_in_active();
    logic [7:0] seq [4];
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_v;
    seq   = '{BC, 8'h5A, BC, 8'h77};
    exp_d = 8'hFF;
    exp_v = 1'b1;
    for (int j = 0; j < 4; j++) begin
      b = seq[j];
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        if (i == 0) begin
          exp_d = seq[j];
          exp_v = (seq[j] != BC);
        end
        n_checks++;
        if (active !== 1'b1 || valid_out !== exp_v || data_out !== exp_d) begin
          n_fail++;
          $display("FAIL comma_active byte%0d bit%0d: act=%b vld=%b dat=%h, want act=1 vld=%b dat=%h",
                   j, 7 - i, active, valid_out, data_out, exp_v, exp_d);
        end
      end
    end
  endtask

  task automatic test_misalign();
    logic [7:0] seq [7];
    logic [7:0] b;
    pulse_reset();
    seq = '{BC, BC, 8'h12, BC, BC, BC, BC};
    for (int j = 0; j < 7; j++) begin
      b = seq[j];
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        n_checks++;
        if (active !== (bitno >= 56) || active !== m_active || valid_out !== 1'b0) begin
          n_fail++;
          $display("FAIL misalign bit%0d: act=%b vld=%b, want act=%b vld=0", bitno, active, valid_out, bitno >= 56);
        end
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    pulse_reset();
    for (int j = 0; j < 5; j++) begin
      b = (j < 4) ? BC : 8'hC3;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
    end
    n_checks++;
    if (active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'hC3) begin
      n_fail++;
      $display("FAIL pre_reset_state: act=%b vld=%b dat=%h, want 1/1/c3", active, valid_out, data_out);
    end
    b = 8'h96;
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    reset_L = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({active, valid_out, data_out} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset: act=%b vld=%b dat=%h, want 0/0/00", active, valid_out, data_out);
    end
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    bitno = 0;
    for (int j = 0; j < 4; j++) begin
      b = BC;
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        n_checks++;
        if (active !== (bitno >= 32) || valid_out !== 1'b0 || data_out !== 8'h00) begin
          n_fail++;
          $display("FAIL relock bit%0d: act=%b vld=%b dat=%h, want act=%b vld=0 dat=00",
                   bitno, active, valid_out, data_out, bitno >= 32);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int r = 0; r < 4; r++) begin
      pulse_reset();
      for (int k = 0; k < 12 + r * 5; k++) begin
        send_bit(1'($urandom_range(0, 1)));
        n_checks++;
        if (active !== m_active || valid_out !== m_valid || data_out !== m_data) begin
          n_fail++;
          $display("FAIL random_hunt r%0d bit%0d: act=%b vld=%b dat=%h, want act=%b vld=%b dat=%h",
                   r, bitno, active, valid_out, data_out, m_active, m_valid, m_data);
        end
      end
      for (int j = 0; j < 40; j++) begin
        if (j < 4 || $urandom_range(0, 3) == 0) b = BC;
        else b = 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
          send_bit(b[i]);
          n_checks++;
          if (active !== m_active || valid_out !== m_valid || data_out !== m_data) begin
            n_fail++;
            $display("FAIL random r%0d byte%0d: act=%b vld=%b dat=%h, want act=%b vld=%b dat=%h",
                     r, j, active, valid_out, data_out, m_active, m_valid, m_data);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_align();
    test_payload();
    test_comma_in_active();
    test_misalign();
    test_reset_mid_byte();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serie_paralelo_8b.md
Name: serie_paralelo_8b

Overview:
Serial-to-parallel receive stage sitting directly upstream of the 8-bit-to-32-bit packer. It samples one serial bit per clk_32f edge, MSB-first. It byte-aligns on the idle comma character and declares the link active after BC_COUNT consecutive aligned commas. Once active, it delivers 8-bit bytes plus a byte-valid flag, each held for 8 clk_32f cycles (one clk_4f period), for the packer to consume.

Parameters:
COMMA, 8'hBC, idle/alignment character
BC_COUNT, 4, consecutive aligned commas required to go active (range 1..15)

Ports:
clk_32f  input  1  serial bit clock; all state on rising edge
reset_L  input  1  reset, asynchronous assert, active-low
data_in  input  1  serial data bit, MSB of each byte first
data_out  output  8  last complete byte received while active
valid_out  output  1  1 = data_out is payload; 0 = idle comma or link not active
active  output  1  1 = link aligned and active

Behaviour:
- Reset (reset_L=0, asynchronous): data_out=8'h00, valid_out=0, active=0, state=UNALIGNED, shift reg=0, bit_cnt=0, bc_cnt=0.
- Window: every edge, sr <= next_sr = {sr[6:0], data_in}.
- UNALIGNED:
  - Each edge, if next_sr==COMMA: bit_cnt<=0, bc_cnt<=1, state<=ALIGNED (or ACTIVE directly if BC_COUNT==1).
  - Otherwise remain in UNALIGNED.
- Byte framing (ALIGNED/ACTIVE):
  - bit_cnt counts bits of the current byte.
  - Edge with bit_cnt==7: byte complete (byte=next_sr), bit_cnt<=0.
  - Otherwise bit_cnt<=bit_cnt+1.
  - Exactly 8 edges per byte.
- ALIGNED, on byte complete:
  - byte==COMMA: bc_cnt<=bc_cnt+1. If bc_cnt+1==BC_COUNT, state<=ACTIVE.
  - byte!=COMMA: state<=UNALIGNED, bc_cnt<=0. Hunting resumes on the next edge.
  - data_out/valid_out unchanged.
- ACTIVE, on byte complete:
  - data_out<=byte; valid_out<=(byte!=COMMA).
  - Both held until the next byte completes.
  - ACTIVE is left only via reset; there is no loss-of-sync detection.
- active is registered: 1 from the edge that completes the BC_COUNT-th aligned comma. That same edge does not update data_out/valid_out.
- Latency: data_out/valid_out change on the same edge that samples the byte's 8th bit (visible one clk_32f later than the LSB on data_in).
- Comma windows are never falsely matched within a continuous aligned comma stream (0xBC has no self-overlap match).
- Reset mid-byte or mid-count: immediate return to the reset values above. A full BC_COUNT comma sequence is required again.
- X/Z on data_in is not handled; the bench must drive 0/1 only.

Decomposition:
- Shared package/include: COMMA constant, state encoding (UNALIGNED=2'd0, ALIGNED=2'd1, ACTIVE=2'd2), BC_COUNT default.
- The 8-bit-to-32-bit packer imports the same COMMA constant.
- No sub-module: single module with shift register, bit counter, comma counter and 3-state FSM.

Test Plan:
1. Hold reset_L=0 for 3 cycles, toggling data_in -> data_out=0x00, valid_out=0, active=0 throughout.
2. After reset, send bits 1,0,1 then 4×0xBC MSB-first -> active rises on the edge sampling bit 35. valid_out stays 0 and data_out stays 0x00.
3. Continue with 0xA5, 0x3C, 0x00, 0xFF -> each appears on data_out for 8 cycles with valid_out=1, updating at edges 43, 51, 59, 67.
4. In ACTIVE, send 0xBC between payloads -> data_out=0xBC with valid_out=0 for 8 cycles. active stays 1.
5. From reset, send 2×0xBC then 0x12, then 4×0xBC -> active stays 0 after the 0x12, then rises at the end of the 4th new comma.
6. Assert reset_L low for 1 cycle at bit 4 of a payload byte while ACTIVE -> outputs immediately 0/0/0. The next 3 commas leave active=0; the 4th sets active=1.
